sample_io_bridge: RTL and testbench

SAMPLE_IO_BRIDGE -- requirements
Module: sample_io_bridge

---
 rtl/sample_io_pkg.sv | 10 +
 rtl/sample_fifo.sv | 37 +++
 rtl/sample_io_bridge.sv | 68 ++++++
 tb/tb_sample_io_bridge.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sample_io_pkg.sv
// sample_io_pkg: shared defaults, counter width and saturating increment for the sample I/O bridge
package sample_io_pkg;
  localparam int DWIDTH_DEF = 32;
  localparam int NCHAN_DEF = 2;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W = 16;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: first-word-fall-through FIFO with synchronous flush; push blocked when full, pop ignored when empty
module sample_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign rdata = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/sample_io_bridge.sv
// sample_io_bridge: channel-tagged ADC->CPU and CPU->DAC sample FIFOs with optional error counters
// Build option: define SAMPLE_IO_ERRCNT_EN to enable the overflow/underrun counters.
module sample_io_bridge
  import sample_io_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int NCHAN = NCHAN_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic [DWIDTH-1:0] adc_data,
  input  logic              adc_valid,
  output logic              adc_ready,
  input  logic              cpu_rd_en,
  output logic [DWIDTH-1:0] cpu_rd_data,
  output logic [CW-1:0]     cpu_rd_chan,
  output logic              in_avail,
  input  logic              cpu_wr_en,
  input  logic [DWIDTH-1:0] cpu_wr_data,
  output logic              out_space,
  output logic [DWIDTH-1:0] dac_data,
  output logic [CW-1:0]     dac_chan,
  output logic              dac_valid,
  input  logic              dac_ready,
  output logic [CNT_W-1:0]  ovf_count,
  output logic [CNT_W-1:0]  unf_count
);
  logic [CW-1:0] rx_chan, tx_chan;
  logic rx_full, rx_empty, tx_full, tx_empty;
  sample_fifo #(.W(DWIDTH + CW), .DEPTH(DEPTH)) u_rx (
    .clock(clock), .reset(reset), .flush(flush), .push(adc_valid), .pop(cpu_rd_en),
    .wdata({rx_chan, adc_data}), .rdata({cpu_rd_chan, cpu_rd_data}), .full(rx_full), .empty(rx_empty)
  );
  sample_fifo #(.W(DWIDTH + CW), .DEPTH(DEPTH)) u_tx (
    .clock(clock), .reset(reset), .flush(flush), .push(cpu_wr_en), .pop(dac_ready),
    .wdata({tx_chan, cpu_wr_data}), .rdata({dac_chan, dac_data}), .full(tx_full), .empty(tx_empty)
  );
  assign adc_ready = !rx_full;
  assign in_avail = !rx_empty;
  assign out_space = !tx_full;
  assign dac_valid = !tx_empty;
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rx_chan <= '0;
      tx_chan <= '0;
    end else begin
      if (adc_valid && !rx_full) rx_chan <= (rx_chan == CW'(NCHAN - 1)) ? '0 : rx_chan + 1'b1;
      if (cpu_wr_en && !tx_full) tx_chan <= (tx_chan == CW'(NCHAN - 1)) ? '0 : tx_chan + 1'b1;
    end
  end
`ifdef SAMPLE_IO_ERRCNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_count <= '0;
      unf_count <= '0;
    end else if (!flush) begin
      if (cpu_wr_en && tx_full) ovf_count <= sat_inc(ovf_count);
      if (cpu_rd_en && rx_empty) unf_count <= sat_inc(unf_count);
    end
  end
`else
  assign ovf_count = '0;
  assign unf_count = '0;
`endif
endmodule

// File: tb/tb_sample_io_bridge.sv
// tb_sample_io_bridge: directed scenarios plus randomized traffic against a queue-based reference model
module tb_sample_io_bridge;
  localparam int DW = 32;
  localparam int NCH = 2;
  localparam int DEP = 8;
`ifdef SAMPLE_IO_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset, flush, adc_valid, cpu_rd_en, cpu_wr_en, dac_ready;
  logic [DW-1:0] adc_data, cpu_wr_data, cpu_rd_data, dac_data;
  logic adc_ready, in_avail, out_space, dac_valid;
  logic [0:0] cpu_rd_chan, dac_chan;
  logic [15:0] ovf_count, unf_count;
  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] rxq_d[$], txq_d[$];
  int rxq_c[$], txq_c[$];
  int m_rx_chan, m_tx_chan, m_ovf, m_unf;

  sample_io_bridge #(.DWIDTH(DW), .NCHAN(NCH), .DEPTH(DEP)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .adc_data(adc_data), .adc_valid(adc_valid), .adc_ready(adc_ready),
    .cpu_rd_en(cpu_rd_en), .cpu_rd_data(cpu_rd_data), .cpu_rd_chan(cpu_rd_chan), .in_avail(in_avail),
    .cpu_wr_en(cpu_wr_en), .cpu_wr_data(cpu_wr_data), .out_space(out_space),
    .dac_data(dac_data), .dac_chan(dac_chan), .dac_valid(dac_valid), .dac_ready(dac_ready),
    .ovf_count(ovf_count), .unf_count(unf_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("adc_ready", adc_ready, rxq_d.size() < DEP);
    check("in_avail", in_avail, rxq_d.size() > 0);
    check("out_space", out_space, txq_d.size() < DEP);
    check("dac_valid", dac_valid, txq_d.size() > 0);
    check("ovf_count", ovf_count, ERRCNT ? m_ovf : 0);
    check("unf_count", unf_count, ERRCNT ? m_unf : 0);
    if (rxq_d.size() > 0) begin
      check("rd_data", cpu_rd_data, rxq_d[0]);
      check("rd_chan", cpu_rd_chan, rxq_c[0]);
    end
    if (txq_d.size() > 0) begin
      check("dac_data", dac_data, txq_d[0]);
      check("dac_chan", dac_chan, txq_c[0]);
    end
  endtask

  task automatic model_step();
    int rx_n, tx_n;
    rx_n = rxq_d.size();
    tx_n = txq_d.size();
    if (reset) begin
      rxq_d.delete(); rxq_c.delete(); txq_d.delete(); txq_c.delete();
      m_rx_chan = 0; m_tx_chan = 0; m_ovf = 0; m_unf = 0;
    end else if (flush) begin
      rxq_d.delete(); rxq_c.delete(); txq_d.delete(); txq_c.delete();
      m_rx_chan = 0; m_tx_chan = 0;
    end else begin
      if (cpu_rd_en && rx_n == 0) m_unf = (m_unf < 65535) ? m_unf + 1 : m_unf;
      if (cpu_rd_en && rx_n > 0) begin void'(rxq_d.pop_front()); void'(rxq_c.pop_front()); end
      if (adc_valid && rx_n < DEP) begin
        rxq_d.push_back(adc_data); rxq_c.push_back(m_rx_chan);
        m_rx_chan = (m_rx_chan + 1) % NCH;
      end
      if (cpu_wr_en && tx_n == DEP) m_ovf = (m_ovf < 65535) ? m_ovf + 1 : m_ovf;
      if (dac_ready && tx_n > 0) begin void'(txq_d.pop_front()); void'(txq_c.pop_front()); end
      if (cpu_wr_en && tx_n < DEP) begin
        txq_d.push_back(cpu_wr_data); txq_c.push_back(m_tx_chan);
        m_tx_chan = (m_tx_chan + 1) % NCH;
      end
    end
  endtask

  task automatic cycle();
    check_outputs();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 0; flush = 0; adc_valid = 0; cpu_rd_en = 0; cpu_wr_en = 0; dac_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  task automatic adc_push(input logic [DW-1:0] d);
    idle(); adc_valid = 1; adc_data = d; cycle(); idle();
  endtask

  task automatic cpu_write(input logic [DW-1:0] d);
    idle(); cpu_wr_en = 1; cpu_wr_data = d; cycle(); idle();
  endtask

  task automatic cpu_read();
    idle(); cpu_rd_en = 1; cycle(); idle();
  endtask

  initial begin
    int cnt;
    int b_adc, b_rd, b_wr, b_dac;
    idle();
    adc_data = '0; cpu_wr_data = '0;
    reset = 1;
    m_rx_chan = 0; m_tx_chan = 0; m_ovf = 0; m_unf = 0;
    @(posedge clock); #1;
    reset = 0;
    check("rst_adc_ready", adc_ready, 1);
    check("rst_out_space", out_space, 1);
    check("rst_in_avail", in_avail, 0);
    check("rst_dac_valid", dac_valid, 0);
    check("rst_ovf", ovf_count, 0);
    check("rst_unf", unf_count, 0);

    // ADC pushes and FWFT reads with channel tags
    do_reset();
    adc_push(32'hA1);
    check("a1_avail", in_avail, 1);
    adc_push(32'hB2);
    adc_push(32'hC3);
    check("rd0_data", cpu_rd_data, 32'hA1); check("rd0_chan", cpu_rd_chan, 0);
    cpu_read();
    check("rd1_data", cpu_rd_data, 32'hB2); check("rd1_chan", cpu_rd_chan, 1);
    cpu_read();
    check("rd2_data", cpu_rd_data, 32'hC3); check("rd2_chan", cpu_rd_chan, 0);
    cpu_read();
    check("rd_empty", in_avail, 0);

    // underrun on empty RX
    do_reset();
    repeat (3) cpu_read();
    check("unf3", unf_count, ERRCNT ? 3 : 0);
    check("unf_avail", in_avail, 0);

    // TX fill to full and overflow
    do_reset();
    for (int i = 0; i < 8; i++) cpu_write(32'h100 + i);
    check("tx_full_space", out_space, 0);
    cpu_write(32'h1FF);
    check("ovf1", ovf_count, ERRCNT ? 1 : 0);
    check("tx_head", dac_data, 32'h100);

    // full TX: simultaneous write and DAC pop
    idle(); cpu_wr_en = 1; cpu_wr_data = 32'h2AA; dac_ready = 1; cycle(); idle();
    check("ovf2", ovf_count, ERRCNT ? 2 : 0);
    check("full_pop_head", dac_data, 32'h101);
    check("full_pop_space", out_space, 1);
    cnt = 0;
    dac_ready = 1;
    for (int i = 0; i < 20 && dac_valid; i++) begin cycle(); cnt++; end
    idle();
    check("drain_occ7", cnt, 7);

    // flush with RX holding 5 entries and tx_chan = 1
    do_reset();
    cpu_read();
    cpu_write(32'h55);
    for (int i = 0; i < 5; i++) adc_push(32'h300 + i);
    idle(); flush = 1; adc_valid = 1; adc_data = 32'hDEAD; cycle(); idle();
    check("flush_avail", in_avail, 0);
    check("flush_dac_valid", dac_valid, 0);
    check("flush_unf_kept", unf_count, ERRCNT ? 1 : 0);
    adc_push(32'h77);
    check("flush_chan0", cpu_rd_chan, 0);
    check("flush_next_data", cpu_rd_data, 32'h77);
    cpu_write(32'h88);
    check("flush_tx_chan0", dac_chan, 0);

    // reset with both FIFOs half full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(); adc_valid = 1; adc_data = 32'h400 + i; cpu_wr_en = 1; cpu_wr_data = 32'h500 + i; cycle();
    end
    idle(); reset = 1; adc_valid = 1; cpu_wr_en = 1; cpu_rd_en = 1; dac_ready = 1; cycle(); idle();
    check("mid_rst_avail", in_avail, 0);
    check("mid_rst_dac_valid", dac_valid, 0);
    check("mid_rst_ready", adc_ready, 1);
    check("mid_rst_space", out_space, 1);

    // randomized traffic with shifting biases to visit full and empty
    for (int p = 0; p < 8; p++) begin
      b_adc = $urandom_range(10, 90); b_rd = $urandom_range(10, 90);
      b_wr = $urandom_range(10, 90); b_dac = $urandom_range(10, 90);
      for (int i = 0; i < 400; i++) begin
        reset = ($urandom_range(0, 299) == 0);
        flush = ($urandom_range(0, 79) == 0);
        adc_valid = ($urandom_range(0, 99) < b_adc);
        cpu_rd_en = ($urandom_range(0, 99) < b_rd);
        cpu_wr_en = ($urandom_range(0, 99) < b_wr);
        dac_ready = ($urandom_range(0, 99) < b_dac);
        adc_data = $urandom;
        cpu_wr_data = $urandom;
        cycle();
      end
    end
    idle();
    check_outputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
